// File: rtl/outer_product_stream_if.sv
// Valid/ready bundle between the vector source, the outer-product engine
// and the downstream matrix accumulation stage.
interface outer_product_stream_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_row;
  logic [IDX_W-1:0]         out_col;
  logic                     out_last;
  logic                     busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );
endinterface

// File: rtl/outer_product_stream.sv
// Sequential outer-product engine: loads vectors a and b element-serially,
// then streams every a[r]*b[c] in row-major order.
module outer_product_stream #(
  parameter int VEC_LEN = 4,
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  outer_product_stream_if.slave s
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                   state_q;
  logic [IDX_W-1:0]         k_q;
  logic signed [DATA_W-1:0] a_q [VEC_LEN];
  logic signed [DATA_W-1:0] b_q [VEC_LEN];
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic [IDX_W-1:0]         out_row_q;
  logic [IDX_W-1:0]         out_col_q;
  logic                     out_last_q;
  logic                     busy_q;

  logic [IDX_W-1:0]         nxt_row_d;
  logic [IDX_W-1:0]         nxt_col_d;
  logic                     nxt_last_d;
  logic signed [OUT_W-1:0]  nxt_prod_d;
  logic                     load_fire_s;
  logic                     out_fire_s;

  // Operands are widened first, so the OUT_W-bit product is exact.
  function automatic logic signed [OUT_W-1:0] mul(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    return OUT_W'(x) * OUT_W'(y);
  endfunction

  assign load_fire_s = s.in_valid && in_ready_q;
  assign out_fire_s  = out_valid_q && s.out_ready;

  // Next element in row-major order, following the one currently presented
  always_comb begin
    nxt_row_d = out_row_q;
    nxt_col_d = out_col_q + IDX_ONE;
    if (out_col_q == LAST_IDX) begin
      nxt_col_d = '0;
      nxt_row_d = out_row_q + IDX_ONE;
    end else begin
      nxt_col_d = out_col_q + IDX_ONE;
    end
    nxt_last_d = (nxt_row_d == LAST_IDX) && (nxt_col_d == LAST_IDX);
    nxt_prod_d = mul(a_q[nxt_row_d], b_q[nxt_col_d]);
  end

  // Vector storage; contents after reset are irrelevant, so no reset term
  always_ff @(posedge clk) begin
    if (load_fire_s) begin
      a_q[k_q] <= s.in_a;
      b_q[k_q] <= s.in_b;
    end
  end

  // Load/emit sequencing with every handshake output registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_fire_s) begin
            if (k_q == LAST_IDX) begin
              // a[0]/b[0] were stored on an earlier edge, so (0,0) is ready now
              k_q         <= '0;
              state_q     <= ST_EMIT;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_data_q  <= mul(a_q[0], b_q[0]);
              out_row_q   <= '0;
              out_col_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              k_q <= k_q + IDX_ONE;
            end
          end
        end
        ST_EMIT: begin
          if (out_fire_s) begin
            if (out_last_q) begin
              state_q     <= ST_LOAD;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_row_q   <= '0;
              out_col_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_row_q  <= nxt_row_d;
              out_col_q  <= nxt_col_d;
              out_data_q <= nxt_prod_d;
              out_last_q <= nxt_last_d;
            end
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          k_q         <= '0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_row   = out_row_q;
  assign s.out_col   = out_col_q;
  assign s.out_last  = out_last_q;
  assign s.busy      = busy_q;
endmodule

// File: tb/tb_outer_product_stream.sv
// Scoreboard bench for outer_product_stream: stimulus pushes hand-computed
// products, a negedge monitor pops and compares on every output transfer.
module tb_outer_product_stream;
  localparam int VEC_LEN = 4;
  localparam int DATA_W  = 8;
  localparam int OUT_W   = 16;
  localparam int IDX_W   = 2;
  localparam int NOUT    = VEC_LEN * VEC_LEN;

  typedef logic signed [DATA_W-1:0] vec_t [VEC_LEN];
  typedef logic signed [OUT_W-1:0]  res_t [NOUT];
  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  outer_product_stream_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  outer_product_stream #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   out_count = 0;
  int   cyc       = 0;
  int   rdy_mode  = 0;
  exp_t exp_q[$];

  vec_t a1 = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
  vec_t b1 = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
  res_t r1 = '{16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd10, 16'sd12, 16'sd14, 16'sd16,
               16'sd15, 16'sd18, 16'sd21, 16'sd24, 16'sd20, 16'sd24, 16'sd28, 16'sd32};
  vec_t a2 = '{8'sh80, 8'sh80, 8'sd127, 8'sd0};
  vec_t b2 = '{8'sh80, 8'sd127, 8'sd127, -8'sd1};
  res_t r2 = '{16'sd16384, -16'sd16256, -16'sd16256, 16'sd128,
               16'sd16384, -16'sd16256, -16'sd16256, 16'sd128,
               -16'sd16256, 16'sd16129, 16'sd16129, -16'sd127,
               16'sd0, 16'sd0, 16'sd0, 16'sd0};
  vec_t a5 = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
  vec_t b5 = '{8'sd2, 8'sd2, 8'sd2, 8'sd2};
  res_t r5 = '{16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2,
               16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2};
  vec_t a6 = '{-8'sd1, 8'sd2, -8'sd3, 8'sd4};
  vec_t b6 = '{8'sd4, -8'sd3, 8'sd2, -8'sd1};
  res_t r6 = '{-16'sd4, 16'sd3, -16'sd2, 16'sd1, 16'sd8, -16'sd6, 16'sd4, -16'sd2,
               -16'sd12, 16'sd9, -16'sd6, 16'sd3, 16'sd16, -16'sd12, 16'sd8, -16'sd4};

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_exp(input res_t r);
    for (int i = 0; i < NOUT; i++) begin
      exp_t e;
      e.data = int'(r[i]);
      e.row  = i / VEC_LEN;
      e.col  = i % VEC_LEN;
      e.last = (i == NOUT - 1) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
    int bound = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && bound < 500) begin
      @(negedge clk);
      bound++;
    end
    if (!bus.in_ready) fail_now("send_timeout");
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_op(input vec_t a, input vec_t b, input res_t r, input int gap);
    push_exp(r);
    for (int i = 0; i < VEC_LEN; i++) begin
      send(a[i], b[i]);
      if (gap > 0 && i < VEC_LEN - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    int bound = 0;
    while (!(bus.in_ready && exp_q.size() == 0) && bound < 1000) begin
      @(negedge clk);
      bound++;
    end
    if (!(bus.in_ready && exp_q.size() == 0)) fail_now(name);
  endtask

  // Cycle counter and out_ready pattern (1,0,0 repeating in mode 1)
  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rdy_mode == 0) begin
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // Monitor: invariants, stall stability and scoreboard pops
  initial begin
    bit   held = 1'b0;
    exp_t hv;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        check("in_ready_vs_valid", int'(bus.in_ready), int'(!bus.out_valid));
        check("busy_vs_valid", int'(bus.busy), int'(bus.out_valid));
        if (held) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'(bus.out_data), hv.data);
          check("stall_row", int'(bus.out_row), hv.row);
          check("stall_col", int'(bus.out_col), hv.col);
          check("stall_last", int'(bus.out_last), hv.last);
        end
        if (bus.out_valid && bus.out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(bus.out_data), e.data);
            check("out_row", int'(bus.out_row), e.row);
            check("out_col", int'(bus.out_col), e.col);
            check("out_last", int'(bus.out_last), e.last);
            out_count++;
          end
        end else if (bus.out_valid) begin
          held    = 1'b1;
          hv.data = int'(bus.out_data);
          hv.row  = int'(bus.out_row);
          hv.col  = int'(bus.out_col);
          hv.last = int'(bus.out_last);
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    int bound;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_row", int'(bus.out_row), 0);
    check("rst_out_col", int'(bus.out_col), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic full-rate operation and its 20-cycle occupancy
    c0 = cyc;
    load_op(a1, b1, r1, 0);
    wait_done("op1_done");
    check("op1_cycles", cyc - c0, 20);

    // Signed extremes
    load_op(a2, b2, r2, 0);
    wait_done("op2_done");

    // Output backpressure
    rdy_mode = 1;
    load_op(a1, b1, r1, 0);
    wait_done("op3_done");
    rdy_mode = 0;
    @(negedge clk);

    // Input gaps during LOAD, then junk held on in_valid through EMIT
    load_op(a1, b1, r1, 3);
    bus.in_valid = 1'b1;
    bound = 0;
    while (!(bus.out_valid && bus.out_ready && bus.out_last) && bound < 500) begin
      bus.in_a = DATA_W'($urandom);
      bus.in_b = DATA_W'($urandom);
      @(negedge clk);
      bound++;
    end
    bus.in_valid = 1'b0;
    if (bound >= 500) fail_now("junk_phase_timeout");
    wait_done("op4_done");

    // Reset after the 5th output of a pending operation
    base = out_count;
    load_op(a1, b1, r1, 0);
    bound = 0;
    while (out_count < base + 5 && bound < 500) begin
      @(negedge clk);
      #1;
      bound++;
    end
    if (out_count < base + 5) fail_now("reset_wait_timeout");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_out_count", out_count, base + 5);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    load_op(a5, b5, r5, 0);
    wait_done("op5_done");

    // Back-to-back: second pair waits on in_ready during the first EMIT
    c0 = cyc;
    load_op(a1, b1, r1, 0);
    load_op(a6, b6, r6, 0);
    wait_done("op6_done");
    check("op6_cycles", cyc - c0, 40);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
